// File: rtl/led_pwm_ctrl_if.sv
// d16 peripheral register bus: select/write strobes, address, write data and
// registered read data.
interface led_pwm_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data;
  logic [15:0]       data_out;

  modport master (
    output en,
    output wr_en,
    output addr,
    output data,
    input  data_out
  );

  modport slave (
    input  en,
    input  wr_en,
    input  addr,
    input  data,
    output data_out
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// LED output peripheral on the d16 bus: per-LED enable mask, PWM duty and
// blink select, with registered read-back and registered LED drive.
module led_pwm_ctrl #(
  parameter int NUM_LEDS  = 8,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 24,
  parameter int ADDR_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_pwm_ctrl_if.slave       bus,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam logic [ADDR_W-1:0] ADDR_MASK  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_BLINK = ADDR_W'(1);

  logic [NUM_LEDS-1:0]  mask_q;
  logic [NUM_LEDS-1:0]  blink_q;
  logic [PWM_BITS-1:0]  duty_q [NUM_LEDS];
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [BLINK_DIV-1:0] presc;
  logic                 phase;

  logic                 wr_stb;
  logic                 rd_stb;
  logic                 wr_mask;
  logic                 wr_blink;
  logic [NUM_LEDS-1:0]  wr_duty;
  logic [NUM_LEDS-1:0]  pwm_on;
  logic [15:0]          rd_val;
  logic                 unused_data;

  assign wr_stb   = bus.en & bus.wr_en;
  assign rd_stb   = bus.en & ~bus.wr_en;
  assign wr_mask  = wr_stb & (bus.addr == ADDR_MASK);
  assign wr_blink = wr_stb & (bus.addr == ADDR_BLINK);

  // Upper write-data bits beyond the register widths are intentionally dropped.
  assign unused_data = ^bus.data;

  always_comb begin
    wr_duty = '0;
    rd_val  = '0;
    if (bus.addr == ADDR_MASK) begin
      rd_val = 16'(mask_q);
    end
    if (bus.addr == ADDR_BLINK) begin
      rd_val = 16'(blink_q);
    end
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.addr == ADDR_W'(i + 2)) begin
        wr_duty[i] = wr_stb;
        rd_val     = 16'(duty_q[i]);
      end
    end
  end

  // All-ones duty means constant on, so full brightness needs no counter compare.
  always_comb begin
    pwm_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_on[i] = (duty_q[i] == '1) ? 1'b1 : (pwm_cnt < duty_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      blink_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_q[i] <= '1;
      end
    end else begin
      if (wr_mask) begin
        mask_q <= bus.data[NUM_LEDS-1:0];
      end
      if (wr_blink) begin
        blink_q <= bus.data[NUM_LEDS-1:0];
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_duty[i]) begin
          duty_q[i] <= bus.data[PWM_BITS-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // A BLINK write restarts the blink period lit, and wins over a coincident wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (wr_blink) begin
      presc <= '0;
      phase <= 1'b1;
    end else begin
      presc <= presc + BLINK_DIV'(1);
      if (presc == '1) begin
        phase <= ~phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_out <= '0;
    end else begin
      led_out <= mask_q & pwm_on & (~blink_q | {NUM_LEDS{phase}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out <= '0;
    end else if (rd_stb) begin
      bus.data_out <= rd_val;
    end
  end

endmodule
